div_unit_seq: RTL and testbench
===============================

Name: div_unit_seq

Overview:
- Multi-cycle integer divide/remainder unit for ALU 2/3. Executes c_DIV, c_DIVU, c_REM and c_REMU (alu_commands_t) using a radix-2 restoring divider, one quotient bit per cycle.
- Sits between the issue stage and writeback, with valid/ready handshakes on both sides.
- Accepts a pipeline flush. Exports a busy flag for the r_WAIT performance counter.

Parameters:
- XLEN, 32, operand/result width; must match core_config_pkg::XLEN.
- TAG_W, 5, width of the destination-register tag; defaults to REG_ADDR_W.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous pipeline flush, kills any in-flight operation
- in_valid  in  1  operation request
- in_ready  out  1  unit can accept an operation
- in_cmd  in  alu_commands_t  requested command
- in_op_a  in  XLEN  dividend (rs1)
- in_op_b  in  XLEN  divisor (rs2)
- in_tag  in  TAG_W  destination register index
- out_valid  out  1  result available
- out_ready  in  1  writeback accepts result
- out_result  out  XLEN  quotient or remainder
- out_tag  out  TAG_W  tag captured with the operation
- out_illegal  out  1  accepted command was not a divide/remainder
- busy  out  1  high in every state except IDLE

Behaviour:
- Clock and reset:
  - One clock (clk).
  - Reset is asynchronous, active-low (rst_n).
  - Reset values: state=IDLE, out_valid=0, out_result=0, out_tag=0, out_illegal=0, busy=0, iteration counter=0. in_ready is therefore 1 once rst_n is released.
- Handshake:
  - in_ready = (state==IDLE) && !flush.
  - An operation is accepted on a rising edge where in_valid && in_ready.
  - Operands, cmd and tag are registered at acceptance. Inputs are don't-care otherwise.
- States: IDLE, CALC, FIX, DONE.
- IDLE, on accept (edge E0):
  - Illegal cmd (not c_DIV/c_DIVU/c_REM/c_REMU): go to DONE with result=0, out_illegal=1.
  - Divisor==0: go to DONE. Quotient=all ones (0xFFFFFFFF). Remainder=dividend unmodified. Applies to both signed and unsigned.
  - Signed overflow (c_DIV/c_REM, dividend=0x80000000, divisor=0xFFFFFFFF): go to DONE. Quotient=0x80000000, remainder=0.
  - Otherwise go to CALC. Store |a| and |b| (absolute values only for signed cmds). Record the quotient sign (sa XOR sb) and the remainder sign (sa). Clear the partial remainder. Set the counter to XLEN-1.
- CALC:
  - Each cycle: shift {rem,quo} left by 1 and bring in the next dividend MSB.
  - If rem >= |b|: subtract |b| and set the quotient LSB.
  - Counter decrements. On the cycle the counter is 0, go to FIX. CALC lasts exactly XLEN cycles.
- FIX:
  - Apply two's-complement negation to the quotient and/or remainder according to the recorded signs.
  - Select the quotient (DIV/DIVU) or the remainder (REM/REMU) into out_result. Go to DONE.
- DONE:
  - out_valid=1; out_result, out_tag and out_illegal are held stable.
  - On out_valid && out_ready, go to IDLE and drop out_valid the next cycle. No new operation is accepted in the same cycle as result handoff.
- Latency, counted from the accept edge E0:
  - Normal operation: out_valid rises at E0+XLEN+2 (34 cycles at XLEN=32).
  - Special cases and illegal cmds: out_valid rises at E0+1.
- Flush:
  - In any state, flush forces the next state to IDLE and clears out_valid and out_illegal. The result is discarded.
  - Flush has priority over accept, out_ready and the CALC progress.
  - in_ready is low during the flush cycle and high on the following cycle.
- Reset mid-operation: immediate return to reset values. No partial result is ever presented.
- Results are bit-exact to RISC-V M-extension semantics. Remainder sign always follows the dividend.

Test Plan:
- DIV 100 / 7 with out_ready=1 -> out_result=14 at E0+34, out_tag equals in_tag, busy high E0+1..E0+34, in_ready low throughout.
- REM -7 % 3 (0xFFFFFFF9, 3) -> 0xFFFFFFFF (-1). DIVU 0xFFFFFFF9 / 3 -> 0x55555553. REMU 0xFFFFFFF9 % 3 -> 0x00000000.
- DIVU 123 / 0 -> 0xFFFFFFFF at E0+1. REM 123 % 0 -> 123. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0; both at E0+1.
- Start DIV, assert flush at the 10th CALC cycle -> out_valid never rises, in_ready=1 next cycle. A back-to-back DIV 20 / 4 -> 5 with correct latency.
- Hold out_ready=0 for 5 cycles after out_valid -> result and tag stable, in_ready stays 0. Release out_ready -> handshake completes, out_valid=0 the next cycle.
- Issue c_ADD -> out_illegal=1, out_result=0 at E0+1.
- Pulse rst_n low mid-CALC -> all outputs at reset values immediately, in_ready=1 after release.

Source files
------------

// File: rtl/div_unit_seq.sv
// Radix-2 restoring divide/remainder unit: one quotient bit per cycle, with
// single-cycle handling of divide-by-zero, signed overflow and non-divide commands.
package div_unit_seq_pkg;
   typedef enum logic [4:0] {
      c_ADD, c_SUB, c_AND, c_OR, c_XOR, c_SLL, c_SRL, c_SRA, c_SLT, c_SLTU,
      c_MUL, c_MULH, c_MULHSU, c_MULHU, c_DIV, c_DIVU, c_REM, c_REMU
   } alu_commands_t;
endpackage

module div_unit_seq
   import div_unit_seq_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                flush,
   input  logic                in_valid,
   output logic                in_ready,
   input  alu_commands_t       in_cmd,
   input  logic [XLEN-1:0]     in_op_a,
   input  logic [XLEN-1:0]     in_op_b,
   input  logic [TAG_W-1:0]    in_tag,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [XLEN-1:0]     out_result,
   output logic [TAG_W-1:0]    out_tag,
   output logic                out_illegal,
   output logic                busy
);

   localparam int CNT_W = $clog2(XLEN);
   localparam logic [XLEN-1:0] ONE     = XLEN'(1);
   localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [XLEN-1:0] ALL_ONE = {XLEN{1'b1}};

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_FIX,
      S_DONE
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [XLEN-1:0]    quo_q, quo_d;
   logic [XLEN-1:0]    rem_q, rem_d;
   logic [XLEN-1:0]    dvs_q, dvs_d;
   logic               neg_quo_q, neg_quo_d;
   logic               neg_rem_q, neg_rem_d;
   logic               is_rem_q, is_rem_d;
   logic [XLEN-1:0]    res_q, res_d;
   logic [TAG_W-1:0]   tag_q, tag_d;
   logic               ill_q, ill_d;

   logic               accept;
   logic               cmd_legal, cmd_signed, cmd_rem;
   logic               a_neg, b_neg;
   logic [XLEN-1:0]    a_abs, b_abs;
   logic [XLEN:0]      rem_shift, rem_diff;
   logic               rem_ge;

   // Valid/ready: a transfer happens on any rising edge where valid && ready are
   // both high; the producer holds its payload stable until then.
   assign in_ready    = (state_q == S_IDLE) && !flush;
   assign accept      = in_valid && in_ready;
   assign out_valid   = (state_q == S_DONE);
   assign busy        = (state_q != S_IDLE);
   assign out_result  = res_q;
   assign out_tag     = tag_q;
   assign out_illegal = ill_q;

   assign cmd_legal  = (in_cmd == c_DIV) || (in_cmd == c_DIVU) ||
                       (in_cmd == c_REM) || (in_cmd == c_REMU);
   assign cmd_signed = (in_cmd == c_DIV) || (in_cmd == c_REM);
   assign cmd_rem    = (in_cmd == c_REM) || (in_cmd == c_REMU);

   assign a_neg = cmd_signed && in_op_a[XLEN-1];
   assign b_neg = cmd_signed && in_op_b[XLEN-1];
   assign a_abs = a_neg ? (~in_op_a + ONE) : in_op_a;
   assign b_abs = b_neg ? (~in_op_b + ONE) : in_op_b;

   // Partial remainder needs one extra bit: an unsigned divisor near 2^XLEN
   // can make the shifted remainder exceed XLEN bits.
   assign rem_shift = {rem_q, quo_q[XLEN-1]};
   assign rem_diff  = rem_shift - {1'b0, dvs_q};
   assign rem_ge    = !rem_diff[XLEN];

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      quo_d     = quo_q;
      rem_d     = rem_q;
      dvs_d     = dvs_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      is_rem_d  = is_rem_q;
      res_d     = res_q;
      tag_d     = tag_q;
      ill_d     = ill_q;

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               tag_d    = in_tag;
               is_rem_d = cmd_rem;
               ill_d    = 1'b0;
               if (!cmd_legal) begin
                  res_d   = '0;
                  ill_d   = 1'b1;
                  state_d = S_DONE;
               end else if (in_op_b == '0) begin
                  res_d   = cmd_rem ? in_op_a : ALL_ONE;
                  state_d = S_DONE;
               end else if (cmd_signed && (in_op_a == INT_MIN) && (in_op_b == ALL_ONE)) begin
                  res_d   = cmd_rem ? '0 : INT_MIN;
                  state_d = S_DONE;
               end else begin
                  quo_d     = a_abs;
                  dvs_d     = b_abs;
                  rem_d     = '0;
                  neg_quo_d = a_neg ^ b_neg;
                  neg_rem_d = a_neg;
                  cnt_d     = CNT_W'(XLEN-1);
                  state_d   = S_CALC;
               end
            end
         end
         S_CALC: begin
            quo_d = {quo_q[XLEN-2:0], rem_ge};
            rem_d = rem_ge ? rem_diff[XLEN-1:0] : rem_shift[XLEN-1:0];
            if (cnt_q == '0) begin
               state_d = S_FIX;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_FIX: begin
            if (is_rem_q) begin
               res_d = neg_rem_q ? (~rem_q + ONE) : rem_q;
            end else begin
               res_d = neg_quo_q ? (~quo_q + ONE) : quo_q;
            end
            state_d = S_DONE;
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Flush outranks everything above, including a same-cycle handoff.
      if (flush) begin
         state_d = S_IDLE;
         ill_d   = 1'b0;
         cnt_d   = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         quo_q     <= '0;
         rem_q     <= '0;
         dvs_q     <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         is_rem_q  <= 1'b0;
         res_q     <= '0;
         tag_q     <= '0;
         ill_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         quo_q     <= quo_d;
         rem_q     <= rem_d;
         dvs_q     <= dvs_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
         is_rem_q  <= is_rem_d;
         res_q     <= res_d;
         tag_q     <= tag_d;
         ill_q     <= ill_d;
      end
   end

endmodule

// File: tb/tb_div_unit_seq.sv
// Directed bench for div_unit_seq: arithmetic results, special cases, latency,
// back-pressure, flush and mid-operation reset.
module tb_div_unit_seq;
   import div_unit_seq_pkg::*;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          flush;
   logic          in_valid;
   logic          in_ready;
   alu_commands_t in_cmd;
   logic [31:0]   in_op_a;
   logic [31:0]   in_op_b;
   logic [4:0]    in_tag;
   logic          out_valid;
   logic          out_ready;
   logic [31:0]   out_result;
   logic [4:0]    out_tag;
   logic          out_illegal;
   logic          busy;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   div_unit_seq #(.XLEN(32), .TAG_W(5)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_cmd      (in_cmd),
      .in_op_a     (in_op_a),
      .in_op_b     (in_op_b),
      .in_tag      (in_tag),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_result  (out_result),
      .out_tag     (out_tag),
      .out_illegal (out_illegal),
      .busy        (busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Drives one request at a falling edge; returns 1 time unit after the accept edge E0.
   task automatic issue(input alu_commands_t cmd, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag);
      @(negedge clk);
      chk1("in_ready_before_issue", in_ready, 1'b1);
      in_valid = 1'b1;
      in_cmd   = cmd;
      in_op_a  = a;
      in_op_b  = b;
      in_tag   = tag;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_op_a  = 32'hDEAD_BEEF;
      in_op_b  = 32'h0BAD_F00D;
   endtask

   // Waits for out_valid; lat is 1 when valid is already high just after E0.
   task automatic wait_valid(input string name, output int lat);
      lat = 1;
      while (out_valid !== 1'b1 && lat < 100) begin
         chk1({name, "_busy"}, busy, 1'b1);
         chk1({name, "_in_ready_low"}, in_ready, 1'b0);
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic run_op(input string name, input alu_commands_t cmd, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] tag, input logic [31:0] exp_res,
                         input logic exp_ill, input int exp_lat);
      int lat;
      out_ready = 1'b1;
      issue(cmd, a, b, tag);
      wait_valid(name, lat);
      chk({name, "_latency"}, lat, exp_lat);
      chk({name, "_result"}, out_result, exp_res);
      chk({name, "_tag"}, 32'(out_tag), 32'(tag));
      chk1({name, "_illegal"}, out_illegal, exp_ill);
      chk1({name, "_busy_done"}, busy, 1'b1);
      @(posedge clk);
      #1;
      chk1({name, "_valid_dropped"}, out_valid, 1'b0);
      chk1({name, "_in_ready_after"}, in_ready, 1'b1);
   endtask

   initial begin
      int  lat;
      logic seen_valid;

      rst_n     = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_cmd    = c_ADD;
      in_op_a   = '0;
      in_op_b   = '0;
      in_tag    = '0;
      out_ready = 1'b1;
      #22;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk1("reset_out_valid", out_valid, 1'b0);
      chk("reset_out_result", out_result, 32'h0);
      chk("reset_out_tag", 32'(out_tag), 32'h0);
      chk1("reset_out_illegal", out_illegal, 1'b0);
      chk1("reset_busy", busy, 1'b0);
      chk1("reset_in_ready", in_ready, 1'b1);

      // Normal divides / remainders
      run_op("div_100_7",    c_DIV,  32'd100,      32'd7,        5'd11, 32'd14,       1'b0, 34);
      run_op("rem_m7_3",     c_REM,  32'hFFFFFFF9, 32'd3,        5'd2,  32'hFFFFFFFF, 1'b0, 34);
      run_op("divu_fff9_3",  c_DIVU, 32'hFFFFFFF9, 32'd3,        5'd3,  32'h55555553, 1'b0, 34);
      run_op("remu_fff9_3",  c_REMU, 32'hFFFFFFF9, 32'd3,        5'd4,  32'h00000000, 1'b0, 34);
      run_op("div_m100_7",   c_DIV,  32'hFFFFFF9C, 32'd7,        5'd5,  32'hFFFFFFF2, 1'b0, 34);
      run_op("rem_m100_7",   c_REM,  32'hFFFFFF9C, 32'd7,        5'd6,  32'hFFFFFFFE, 1'b0, 34);
      run_op("div_7_m2",     c_DIV,  32'd7,        32'hFFFFFFFE, 5'd7,  32'hFFFFFFFD, 1'b0, 34);
      run_op("rem_7_m2",     c_REM,  32'd7,        32'hFFFFFFFE, 5'd8,  32'd1,        1'b0, 34);
      run_op("divu_max_max", c_DIVU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd9,  32'd1,        1'b0, 34);
      run_op("remu_big",     c_REMU, 32'hFFFFFFFE, 32'hFFFFFFFF, 5'd10, 32'hFFFFFFFE, 1'b0, 34);

      // Special cases resolve in one cycle
      run_op("divu_by0",     c_DIVU, 32'd123,      32'd0,        5'd12, 32'hFFFFFFFF, 1'b0, 1);
      run_op("rem_by0",      c_REM,  32'd123,      32'd0,        5'd13, 32'd123,      1'b0, 1);
      run_op("div_by0_neg",  c_DIV,  32'hFFFFFFF9, 32'd0,        5'd14, 32'hFFFFFFFF, 1'b0, 1);
      run_op("div_ovf",      c_DIV,  32'h80000000, 32'hFFFFFFFF, 5'd15, 32'h80000000, 1'b0, 1);
      run_op("rem_ovf",      c_REM,  32'h80000000, 32'hFFFFFFFF, 5'd16, 32'h00000000, 1'b0, 1);
      run_op("illegal_add",  c_ADD,  32'd5,        32'd6,        5'd17, 32'h00000000, 1'b1, 1);

      // Flush at the 10th CALC cycle
      issue(c_DIV, 32'd1000, 32'd3, 5'd20);
      repeat (9) begin
         @(posedge clk);
         #1;
      end
      flush = 1'b1;
      #1;
      chk1("flush_in_ready_low", in_ready, 1'b0);
      @(posedge clk);
      #1;
      flush = 1'b0;
      #1;
      chk1("flush_in_ready_next", in_ready, 1'b1);
      chk1("flush_busy_cleared", busy, 1'b0);
      seen_valid = 1'b0;
      repeat (30) begin
         @(posedge clk);
         #1;
         if (out_valid === 1'b1) seen_valid = 1'b1;
      end
      chk1("flush_no_valid", seen_valid, 1'b0);
      flush = 1'b1;
      #1;
      chk1("flush_idle_in_ready_low", in_ready, 1'b0);
      flush = 1'b0;
      run_op("div_20_4_after_flush", c_DIV, 32'd20, 32'd4, 5'd21, 32'd5, 1'b0, 34);

      // Back-pressure: hold out_ready low for five cycles after valid
      out_ready = 1'b0;
      issue(c_DIVU, 32'd1000, 32'd10, 5'd9);
      wait_valid("stall", lat);
      chk("stall_latency", lat, 34);
      repeat (5) begin
         chk1("stall_valid_held", out_valid, 1'b1);
         chk("stall_result_held", out_result, 32'd100);
         chk("stall_tag_held", 32'(out_tag), 32'd9);
         chk1("stall_in_ready_low", in_ready, 1'b0);
         @(posedge clk);
         #1;
      end
      chk1("stall_valid_still", out_valid, 1'b1);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk1("stall_valid_dropped", out_valid, 1'b0);
      chk1("stall_in_ready_back", in_ready, 1'b1);

      // Flush in DONE clears out_valid and out_illegal
      out_ready = 1'b0;
      issue(c_SUB, 32'd1, 32'd2, 5'd22);
      chk1("done_flush_pre_valid", out_valid, 1'b1);
      chk1("done_flush_pre_illegal", out_illegal, 1'b1);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      out_ready = 1'b1;
      chk1("done_flush_valid", out_valid, 1'b0);
      chk1("done_flush_illegal", out_illegal, 1'b0);

      // Reset mid-CALC
      issue(c_DIV, 32'd5000, 32'd7, 5'd23);
      repeat (5) begin
         @(posedge clk);
         #1;
      end
      chk1("pre_reset_busy", busy, 1'b1);
      rst_n = 1'b0;
      #1;
      chk1("midrst_out_valid", out_valid, 1'b0);
      chk("midrst_out_result", out_result, 32'h0);
      chk("midrst_out_tag", 32'(out_tag), 32'h0);
      chk1("midrst_out_illegal", out_illegal, 1'b0);
      chk1("midrst_busy", busy, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk1("midrst_in_ready_after", in_ready, 1'b1);
      run_op("divu_after_reset", c_DIVU, 32'd5000, 32'd7, 5'd24, 32'd714, 1'b0, 34);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
